// File: rtl/strobe_cmp_if.sv
`default_nettype none
// ============================================================================
// Module      : strobe_cmp_if
// Description : Pin-compare bus for one strobe_cmp channel. The tester
//               sequencer (master) drives cycle timing, the DUT pin sample,
//               the per-vector expected value and mask, and reads back the
//               per-vector result and the accumulated statistics.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Signals (master -> slave):
//   EN            run enable
//   CYCLE_LENGTH  clocks per tester cycle
//   STROBE_START  first counter value of compare window (inclusive)
//   STROBE_END    last counter value of compare window (inclusive)
//   DUT_IN        DUT output pin
//   EXPECT        expected pin value for current vector
//   MASK          don't-care vector when 1
//   CLR_STATS     synchronous clear of fail statistics
// Signals (slave -> master):
//   RESULT_VALID  one-clock pulse, vector result available
//   FAIL          vector failed (qualified by RESULT_VALID, held otherwise)
//   CAPTURED      pin value at the last in-window sample
//   STICKY_FAIL   any failure since reset / CLR_STATS
//   FAIL_COUNT    saturating failed-vector count
//   FIRST_FAIL_IDX vector index of first failure
//   VEC_IDX       completed-vector count (wraps)
// ============================================================================
interface strobe_cmp_if #(
  parameter int CNT_W = 16
);
  logic             EN;
  logic [7:0]       CYCLE_LENGTH;
  logic [7:0]       STROBE_START;
  logic [7:0]       STROBE_END;
  logic             DUT_IN;
  logic             EXPECT;
  logic             MASK;
  logic             CLR_STATS;

  logic             RESULT_VALID;
  logic             FAIL;
  logic             CAPTURED;
  logic             STICKY_FAIL;
  logic [CNT_W-1:0] FAIL_COUNT;
  logic [CNT_W-1:0] FIRST_FAIL_IDX;
  logic [CNT_W-1:0] VEC_IDX;

  // Tester sequencer side.
  modport master (
    output EN, CYCLE_LENGTH, STROBE_START, STROBE_END,
    output DUT_IN, EXPECT, MASK, CLR_STATS,
    input  RESULT_VALID, FAIL, CAPTURED, STICKY_FAIL,
    input  FAIL_COUNT, FIRST_FAIL_IDX, VEC_IDX
  );

  // Compare channel side.
  modport slave (
    input  EN, CYCLE_LENGTH, STROBE_START, STROBE_END,
    input  DUT_IN, EXPECT, MASK, CLR_STATS,
    output RESULT_VALID, FAIL, CAPTURED, STICKY_FAIL,
    output FAIL_COUNT, FIRST_FAIL_IDX, VEC_IDX
  );
endinterface
`default_nettype wire

// File: rtl/strobe_cmp.sv
`default_nettype none
// ============================================================================
// Module      : strobe_cmp
// Description : Receive-side pin comparator. Samples a DUT output pin inside a
//               programmable strobe window of each tester cycle, compares it
//               to the per-vector expected value, reports pass/fail per
//               vector and keeps a saturating fail count plus the index of
//               the first failing vector.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports:
//   CLK   system clock
//   RST   asynchronous, active-low reset
//   bus   strobe_cmp_if.slave (timing, pin, expect/mask, results, stats)
// Parameters:
//   CNT_W width of vector index and fail counter (>= 2)
// Configuration macro:
//   STROBE_SYNC_EN  when defined, DUT_IN passes through a two-flop
//                   synchronizer before compare and capture; strobe
//                   positions then refer to the pin value two clocks earlier.
// ============================================================================
module strobe_cmp #(
  parameter int CNT_W = 16
) (
  input  wire logic   CLK,
  input  wire logic   RST,
  strobe_cmp_if.slave bus
);

  localparam logic [7:0]       c_CNT_FIRST = 8'd1;
  localparam logic [CNT_W-1:0] c_IDX_ONE   = CNT_W'(1);

  // --------------------------------------------------------------------------
  // Pin sample path
  // --------------------------------------------------------------------------
  logic w_din;

`ifdef STROBE_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], bus.DUT_IN};
    end
  end

  assign w_din = r_sync[1];
`else
  assign w_din = bus.DUT_IN;
`endif

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [7:0]       r_cnt;        // position within tester cycle, 1-based
  logic             r_exp;        // EXPECT latched at vector start
  logic             r_mask;       // MASK latched at vector start
  logic             r_acc;        // any mismatch so far in this vector
  logic             r_valid;
  logic             r_fail;
  logic             r_captured;
  logic             r_sticky;
  logic [CNT_W-1:0] r_fail_cnt;
  logic [CNT_W-1:0] r_first_idx;
  logic [CNT_W-1:0] r_vec_idx;

  // --------------------------------------------------------------------------
  // Cycle decode and compare
  // --------------------------------------------------------------------------
  logic w_last;       // counter sits on the final clock of the tester cycle
  logic w_start;      // first clock of a running vector
  logic w_end;        // final clock of a running vector
  logic w_exp_cur;    // expected value in force this clock
  logic w_mask_cur;   // mask in force this clock
  logic w_win;        // this clock lies inside the strobe window
  logic w_mis;        // in-window, unmasked mismatch this clock
  logic w_acc_nxt;    // accumulator including this clock's compare
  logic w_vec_fail;   // a failing result is produced this clock
  logic w_cnt_sat;    // fail counter already at all-ones

  always_comb begin
    // ">=" rather than "==" folds CYCLE_LENGTH 0 and 1 into one-clock
    // vectors and keeps the counter from running away if CYCLE_LENGTH is
    // lowered below the current position.
    w_last     = (r_cnt >= bus.CYCLE_LENGTH);
    w_start    = bus.EN && (r_cnt == c_CNT_FIRST);
    w_end      = bus.EN && w_last;

    // On the start clock the latches are still loading, so that clock's own
    // compare must use the live EXPECT/MASK values.
    w_exp_cur  = w_start ? bus.EXPECT : r_exp;
    w_mask_cur = w_start ? bus.MASK   : r_mask;

    // START=0, START>END and START>CYCLE_LENGTH all yield an empty window.
    w_win      = bus.EN
              && (bus.STROBE_START != 8'd0)
              && (bus.STROBE_START <= bus.CYCLE_LENGTH)
              && (bus.STROBE_START <= r_cnt)
              && (r_cnt <= bus.STROBE_END);

    w_mis      = w_win && !w_mask_cur && (w_din != w_exp_cur);

    // A new vector discards history but keeps its own first compare.
    w_acc_nxt  = w_mis || (r_acc && !w_start);
    w_vec_fail = w_end && w_acc_nxt;
    w_cnt_sat  = &r_fail_cnt;
  end

  // --------------------------------------------------------------------------
  // Cycle counter, latches, accumulator and capture
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt      <= c_CNT_FIRST;
      r_exp      <= 1'b0;
      r_mask     <= 1'b0;
      r_acc      <= 1'b0;
      r_captured <= 1'b0;
    end else begin
      if (!bus.EN || w_last) begin
        r_cnt <= c_CNT_FIRST;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end

      if (w_start) begin
        r_exp  <= bus.EXPECT;
        r_mask <= bus.MASK;
      end

      // With EN low nothing is in-window, so the accumulator simply holds
      // and the stale value is dropped at the next vector start.
      r_acc <= w_acc_nxt;

      if (w_win) begin
        r_captured <= w_din;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-vector result
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_valid   <= 1'b0;
      r_fail    <= 1'b0;
      r_vec_idx <= '0;
    end else begin
      r_valid <= w_end;
      if (w_end) begin
        r_fail    <= w_acc_nxt;
        r_vec_idx <= r_vec_idx + c_IDX_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Fail statistics
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sticky    <= 1'b0;
      r_fail_cnt  <= '0;
      r_first_idx <= '0;
    end else if (bus.CLR_STATS) begin
      // Clear takes precedence, but a failure landing on the same clock is
      // still recorded as the first one after the clear.
      r_sticky    <= w_vec_fail;
      r_fail_cnt  <= {{(CNT_W-1){1'b0}}, w_vec_fail};
      r_first_idx <= w_vec_fail ? r_vec_idx : '0;
    end else if (w_vec_fail) begin
      r_sticky <= 1'b1;
      if (!w_cnt_sat) begin
        r_fail_cnt <= r_fail_cnt + c_IDX_ONE;
      end
      if (!r_sticky) begin
        r_first_idx <= r_vec_idx;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.RESULT_VALID   = r_valid;
  assign bus.FAIL           = r_fail;
  assign bus.CAPTURED       = r_captured;
  assign bus.STICKY_FAIL    = r_sticky;
  assign bus.FAIL_COUNT     = r_fail_cnt;
  assign bus.FIRST_FAIL_IDX = r_first_idx;
  assign bus.VEC_IDX        = r_vec_idx;

endmodule
`default_nettype wire

// File: tb/tb_strobe_cmp.sv
`default_nettype none
// ============================================================================
// Module      : tb_strobe_cmp
// Description : Self-checking bench for strobe_cmp. Vectors are described as
//               a per-position pin pattern; a vector-level model derives the
//               expected result and statistics, and a negedge process
//               compares every cycle. Literal checks pin key points.
// Revision    : 1.0  initial release
// ============================================================================
module tb_strobe_cmp;

  localparam int CNT_W = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  always #5 CLK = ~CLK;

  strobe_cmp_if #(.CNT_W(CNT_W)) bus ();

  strobe_cmp #(.CNT_W(CNT_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // Model state
  bit             m_valid, m_fail, m_cap, m_sticky;
  logic [CNT_W-1:0] m_cnt, m_first, m_vec;
  bit             chk_on = 1'b0;
  int             n_pass = 0;
  int             n_total = 0;

  localparam logic [31:0] ALL1 = 32'hFFFF_FFFF;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
  endtask

  function automatic bit in_win(input int p, input int cl, input int s, input int e);
    return (s != 0) && (s <= cl) && (s <= p) && (p <= e);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_fail = 0; m_cap = 0; m_sticky = 0;
    m_cnt = '0; m_first = '0; m_vec = '0;
  endtask

  task automatic model_clear();
    m_cnt = '0; m_sticky = 0; m_first = '0;
  endtask

  task automatic model_result(input bit f);
    m_valid = 1;
    m_fail  = f;
    if (f) begin
      if (!m_sticky) m_first = m_vec;
      m_sticky = 1;
      if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
    end
    m_vec = m_vec + 1'b1;
  endtask

  // Every cycle compare against the model.
  always @(negedge CLK) begin
    if (chk_on) begin
      check("valid", 16'(bus.RESULT_VALID), 16'(m_valid));
      check("fail", 16'(bus.FAIL), 16'(m_fail));
      if (m_valid) check("captured", 16'(bus.CAPTURED), 16'(m_cap));
      check("sticky", 16'(bus.STICKY_FAIL), 16'(m_sticky));
      check("fail_count", 16'(bus.FAIL_COUNT), 16'(m_cnt));
      check("first_fail_idx", 16'(bus.FIRST_FAIL_IDX), 16'(m_first));
      check("vec_idx", 16'(bus.VEC_IDX), 16'(m_vec));
    end
  end

  // Runs one vector starting at counter position 1. din bit p is the pin
  // value at position p. n_on>0 and shorter than the vector drops EN after
  // n_on positions (one EN-low clock follows unless rst_abort is set, in
  // which case the caller resets). clr_pos pulses CLR_STATS at that position.
  // EXPECT/MASK are inverted after position 1 to prove they are latched.
  task automatic run_vec(input int cl, input int s, input int e, input bit exp, input bit msk,
                         input logic [31:0] din, input int n_on, input int clr_pos,
                         input bit rst_abort);
    int len, last_on, steps;
    bit full, vf;
    len     = (cl <= 1) ? 1 : cl;
    full    = (n_on == 0) || (n_on >= len);
    last_on = full ? len : n_on;
    steps   = full ? len : (rst_abort ? n_on : n_on + 1);
    vf      = 0;
    bus.CYCLE_LENGTH = 8'(cl);
    bus.STROBE_START = 8'(s);
    bus.STROBE_END   = 8'(e);
    for (int p = 1; p <= steps; p++) begin
      bus.EN        = (p <= last_on);
      bus.DUT_IN    = din[p];
      bus.EXPECT    = (p == 1) ? exp : ~exp;
      bus.MASK      = (p == 1) ? msk : ~msk;
      bus.CLR_STATS = (p == clr_pos);
      @(posedge CLK); #1;
      m_valid = 0;
      if (p == clr_pos) model_clear();
      if (p <= last_on && in_win(p, cl, s, e)) begin
        m_cap = din[p];
        if (!msk && (din[p] != exp)) vf = 1;
      end
      if (full && p == len) model_result(vf);
    end
    bus.CLR_STATS = 1'b0;
  endtask

  task automatic vec(input int cl, input int s, input int e, input bit exp, input bit msk,
                     input logic [31:0] din);
    run_vec(cl, s, e, exp, msk, din, 0, 0, 1'b0);
  endtask

  task automatic idle(input int n);
    bus.EN = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      m_valid = 0;
    end
  endtask

  // Called at posedge+1. Asserts reset between edges, optionally checks the
  // outputs cleared without a clock, releases after one clock.
  task automatic do_reset(input bit chk_now);
    RST = 1'b0;
    #1;
    if (chk_now) begin
      check("rst_valid", 16'(bus.RESULT_VALID), 16'd0);
      check("rst_fail", 16'(bus.FAIL), 16'd0);
      check("rst_captured", 16'(bus.CAPTURED), 16'd0);
      check("rst_sticky", 16'(bus.STICKY_FAIL), 16'd0);
      check("rst_count", 16'(bus.FAIL_COUNT), 16'd0);
      check("rst_first", 16'(bus.FIRST_FAIL_IDX), 16'd0);
      check("rst_vec", 16'(bus.VEC_IDX), 16'd0);
    end
    model_reset();
    @(posedge CLK); #1;
    m_valid = 0;
    RST = 1'b1;
  endtask

  initial begin
    bus.EN = 1'b0; bus.CYCLE_LENGTH = 8'd10; bus.STROBE_START = 8'd5; bus.STROBE_END = 8'd5;
    bus.DUT_IN = 1'b0; bus.EXPECT = 1'b0; bus.MASK = 1'b0; bus.CLR_STATS = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    chk_on = 1'b1;

    // Three passing edge-strobe vectors.
    repeat (3) vec(10, 5, 5, 1'b1, 1'b0, ALL1);
    check("t1_vec_idx", 16'(bus.VEC_IDX), 16'd3);
    check("t1_fail_count", 16'(bus.FAIL_COUNT), 16'd0);
    check("t1_fail", 16'(bus.FAIL), 16'd0);

    // Mismatch at the strobe of vector 2 only.
    do_reset(1'b0);
    vec(10, 5, 5, 1'b1, 1'b0, ALL1);
    vec(10, 5, 5, 1'b1, 1'b0, 32'hFFFF_FFDF);
    check("t2_fail", 16'(bus.FAIL), 16'd1);
    check("t2_captured", 16'(bus.CAPTURED), 16'd0);
    check("t2_fail_count", 16'(bus.FAIL_COUNT), 16'd1);
    check("t2_first_idx", 16'(bus.FIRST_FAIL_IDX), 16'd1);
    check("t2_sticky", 16'(bus.STICKY_FAIL), 16'd1);
    vec(10, 5, 5, 1'b1, 1'b0, ALL1);
    check("t2_v3_fail", 16'(bus.FAIL), 16'd0);

    // Window strobe 3..8: glitch inside fails, glitch outside passes.
    vec(10, 3, 8, 1'b0, 1'b0, 32'h0000_0040);
    check("t3_in_glitch", 16'(bus.FAIL), 16'd1);
    vec(10, 3, 8, 1'b0, 1'b0, 32'h0000_0200);
    check("t3_out_glitch", 16'(bus.FAIL), 16'd0);
    vec(10, 3, 10, 1'b0, 1'b0, 32'h0000_0400);     // mismatch on the end clock
    check("t3_end_clock", 16'(bus.FAIL), 16'd1);
    check("t3_fail_count", 16'(bus.FAIL_COUNT), 16'd3);

    // Masked vector, inverted window, empty windows.
    vec(10, 3, 8, 1'b1, 1'b1, 32'h0);
    check("t4_masked", 16'(bus.FAIL), 16'd0);
    check("t4_count_kept", 16'(bus.FAIL_COUNT), 16'd3);
    vec(10, 9, 4, 1'b1, 1'b0, 32'h0);
    check("t4_inverted", 16'(bus.FAIL), 16'd0);
    vec(10, 5, 5, 1'b1, 1'b0, ALL1);
    vec(10, 0, 5, 1'b1, 1'b0, 32'h0);
    check("t4_start0_cap", 16'(bus.CAPTURED), 16'd1);
    vec(10, 11, 12, 1'b1, 1'b0, 32'h0);
    check("t4_past_len", 16'(bus.FAIL), 16'd0);

    // One-clock vectors and start-clock compare using the live EXPECT.
    vec(1, 1, 1, 1'b1, 1'b0, 32'h0);
    vec(1, 1, 1, 1'b1, 1'b0, ALL1);
    vec(0, 1, 1, 1'b1, 1'b0, 32'h0);
    vec(4, 1, 1, 1'b0, 1'b0, 32'h0000_0002);
    check("t4_start_cmp", 16'(bus.FAIL), 16'd1);

    // Saturation, wrap, clear, clear coincident with a fail.
    do_reset(1'b0);
    repeat (20) vec(4, 2, 2, 1'b1, 1'b0, 32'h0);
    check("t5_sat", 16'(bus.FAIL_COUNT), 16'd15);
    check("t5_first", 16'(bus.FIRST_FAIL_IDX), 16'd0);
    check("t5_wrap", 16'(bus.VEC_IDX), 16'd4);
    run_vec(4, 2, 2, 1'b1, 1'b0, ALL1, 0, 2, 1'b0);
    check("t5_clr_count", 16'(bus.FAIL_COUNT), 16'd0);
    check("t5_clr_sticky", 16'(bus.STICKY_FAIL), 16'd0);
    check("t5_clr_vec", 16'(bus.VEC_IDX), 16'd5);
    run_vec(4, 2, 2, 1'b1, 1'b0, 32'h0, 0, 4, 1'b0);
    check("t5_coin_count", 16'(bus.FAIL_COUNT), 16'd1);
    check("t5_coin_sticky", 16'(bus.STICKY_FAIL), 16'd1);
    check("t5_coin_first", 16'(bus.FIRST_FAIL_IDX), 16'd5);
    vec(4, 2, 2, 1'b1, 1'b0, 32'h0);
    check("t5_first_kept", 16'(bus.FIRST_FAIL_IDX), 16'd5);

    // EN dropped at counter 4 of a failing vector, then a clean vector.
    run_vec(10, 2, 2, 1'b1, 1'b0, 32'h0, 3, 0, 1'b0);
    check("t6_no_valid", 16'(bus.RESULT_VALID), 16'd0);
    check("t6_vec_held", 16'(bus.VEC_IDX), 16'd7);
    vec(10, 5, 5, 1'b1, 1'b0, ALL1);
    check("t6_acc_cleared", 16'(bus.FAIL), 16'd0);

    // Reset mid-vector, then the counter must restart at 1.
    run_vec(10, 2, 2, 1'b1, 1'b0, 32'h0, 3, 0, 1'b1);
    do_reset(1'b1);
    vec(10, 5, 5, 1'b1, 1'b0, ALL1);
    check("t6_restart_valid", 16'(bus.RESULT_VALID), 16'd1);
    check("t6_restart_vec", 16'(bus.VEC_IDX), 16'd1);

    idle(3);
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard bound on run time.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/strobe_cmp.md
Name: strobe_cmp

Overview:
- Receive-side companion of the force-format drive register: samples a DUT output pin inside a programmable strobe window of each tester cycle.
- Compares each sample against a per-vector expected value and reports pass/fail per vector.
- Keeps a saturating fail count and the index of the first failing vector.
- Sits in the ASIC tester pin electronics, one instance per DUT output pin, sharing the cycle timing inputs with the drive registers.

Parameters:
CNT_W, 16, width of vector index and fail counter

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous, active-low reset
EN  input  1  run enable; low holds cycle counter at 1 and freezes vector index
CYCLE_LENGTH  input  8  clocks per tester cycle
STROBE_START  input  8  first counter value of compare window (inclusive)
STROBE_END  input  8  last counter value of compare window (inclusive)
DUT_IN  input  1  DUT output pin
EXPECT  input  1  expected pin value for current vector
MASK  input  1  1 = don't-care vector, never fails
CLR_STATS  input  1  synchronous clear of fail count, sticky flag, first-fail index
RESULT_VALID  output  1  one-clock pulse, vector result available
FAIL  output  1  vector failed; qualified by RESULT_VALID
CAPTURED  output  1  DUT_IN value at the last in-window sample of the vector
STICKY_FAIL  output  1  set on any failure since reset or CLR_STATS
FAIL_COUNT  output  CNT_W  saturating count of failed vectors
FIRST_FAIL_IDX  output  CNT_W  vector index of first failure
VEC_IDX  output  CNT_W  completed-vector count, wraps at 2^CNT_W

Behaviour:
- Reset (RST=0, async): counter=1, all outputs 0, internal fail accumulator 0.
- Cycle counter:
  - Posedge: if EN=0 or counter==CYCLE_LENGTH, counter<=1; else counter<=counter+1.
  - CYCLE_LENGTH of 0 or 1 gives a one-clock vector.
- Vector start (counter==1 with EN=1):
  - Latch EXPECT and MASK.
  - Clear the fail accumulator, except for that clock's own compare.
- Window:
  - Active when EN=1 and STROBE_START<=counter<=STROBE_END.
  - START>END, START=0, or START>CYCLE_LENGTH: no window; the vector passes and CAPTURED is unchanged.
  - Each in-window clock: CAPTURED<=DUT_IN.
  - If latched MASK=0 and DUT_IN!=latched EXPECT, set the accumulator.
  - STROBE_START==STROBE_END gives edge strobe; otherwise window strobe, where any single mismatch fails.
- Vector end (counter==CYCLE_LENGTH with EN=1):
  - On the next clock, RESULT_VALID=1 for exactly one clock.
  - FAIL = accumulator OR the end-clock compare.
  - VEC_IDX increments in the same clock as RESULT_VALID.
- On a fail result:
  - FAIL_COUNT increments, saturating at all-ones.
  - STICKY_FAIL<=1.
  - If STICKY_FAIL was 0, FIRST_FAIL_IDX<=VEC_IDX (pre-increment value).
- CLR_STATS:
  - Clears FAIL_COUNT, STICKY_FAIL and FIRST_FAIL_IDX; does not touch VEC_IDX or the counter.
  - If a fail result lands in the same clock, CLR_STATS wins, then that fail is counted: FAIL_COUNT=1, STICKY=1, FIRST_FAIL_IDX=current index.
- EN deasserted mid-vector: the partial vector is discarded, with no RESULT_VALID. The accumulator clears on the next vector start.
- FAIL holds its value between RESULT_VALID pulses.
- Timing inputs are quasi-static; changes take effect on the next clock.

Optional Feature:
STROBE_SYNC_EN
- Defined: DUT_IN passes through a two-flop synchronizer (reset 0) before compare and CAPTURED. Strobe positions refer to the synchronized signal, i.e. the pin value two clocks earlier.
- Undefined: DUT_IN is sampled directly, with no added latency.

Test Plan:
- CYCLE_LENGTH=10, START=END=5, EXPECT=1, MASK=0, DUT_IN=1 for 3 vectors -> three RESULT_VALID pulses 10 clocks apart, FAIL=0, VEC_IDX=3, FAIL_COUNT=0.
- Same setup, DUT_IN=0 only during counter 5 of vector 2 -> FAIL=1 on vector 2 only, FAIL_COUNT=1, FIRST_FAIL_IDX=1, STICKY_FAIL=1, CAPTURED=0.
- Window START=3, END=8, EXPECT=0, one-clock glitch DUT_IN=1 at counter 6 -> vector fails. Same glitch at counter 9 -> vector passes.
- MASK=1, DUT_IN opposite of EXPECT for whole vector -> FAIL=0, FAIL_COUNT unchanged. START=9, END=4 with mismatching DUT_IN -> FAIL=0.
- CNT_W=4, 20 consecutive failing vectors -> FAIL_COUNT saturates at 15, FIRST_FAIL_IDX=0, VEC_IDX wraps to 4. CLR_STATS pulse -> FAIL_COUNT=0, STICKY_FAIL=0.
- EN dropped at counter 4 of a failing vector, RST pulsed low mid-vector -> no RESULT_VALID for that vector, counter restarts at 1. After reset all outputs are 0 immediately, without waiting for a CLK edge.
